// File: rtl/player_motion.sv
// player_motion: per-player position engine with walking, clamped jump/gravity arc,
// crouch, facing and freeze, stepped by an internal tick enable on the main clock.
// state | meaning
// 00    | GROUNDED: on the floor, walking allowed
// 01    | CROUCH: on the floor crouched, no x motion
// 10    | AIRBORNE: jump/fall arc under gravity
module player_motion #(
  parameter int POS_W     = 10,
  parameter int VEL_W     = 6,
  parameter int TICK_DIV  = 714_285,
  parameter int X_INIT    = 300,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 600,
  parameter int Y_GROUND  = 300,
  parameter int Y_MIN     = 40,
  parameter int WALK_STEP = 1,
  parameter int JUMP_VEL  = 12,
  parameter int GRAVITY   = 1,
  parameter int MAX_FALL  = 16,
  parameter int FACE_INIT = 0
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             left,
  input  logic             right,
  input  logic             up,
  input  logic             down,
  input  logic             freeze,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             facing,
  output logic [1:0]       state,
  output logic             tick,
  output logic             landed
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic [POS_W-1:0] X_INIT_P   = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] X_MIN_P    = POS_W'(X_MIN);
  localparam logic [POS_W-1:0] X_MAX_P    = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] Y_GROUND_P = POS_W'(Y_GROUND);
  localparam logic [POS_W-1:0] Y_MIN_P    = POS_W'(Y_MIN);

  localparam logic signed [POS_W:0]   X_MIN_E    = (POS_W+1)'(X_MIN);
  localparam logic signed [POS_W:0]   X_MAX_E    = (POS_W+1)'(X_MAX);
  localparam logic signed [POS_W:0]   STEP_E     = (POS_W+1)'(WALK_STEP);
  localparam logic signed [POS_W+1:0] Y_GROUND_E = (POS_W+2)'(Y_GROUND);
  localparam logic signed [POS_W+1:0] Y_MIN_E    = (POS_W+2)'(Y_MIN);

  localparam logic signed [VEL_W-1:0] JUMP_V     = VEL_W'(JUMP_VEL);
  localparam logic signed [VEL_W:0]   GRAV_E     = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W:0]   NEG_FALL_E = (VEL_W+1)'(-MAX_FALL);

  typedef enum logic [1:0] {
    GROUNDED = 2'b00,
    CROUCH   = 2'b01,
    AIRBORNE = 2'b10
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [POS_W-1:0]        pos_x_q, pos_x_d;
  logic [POS_W-1:0]        pos_y_q, pos_y_d;
  logic signed [VEL_W-1:0] vy_q, vy_d;
  logic                    facing_q, facing_d;
  logic                    armed_q, armed_d;
  logic                    landed_q, landed_d;

  logic                    tick_w, upd, move_l, move_r, launch;
  logic                    touchdown, hit_ceiling;
  logic signed [POS_W:0]   nx;
  logic [POS_W-1:0]        nx_clamped;
  logic signed [POS_W+1:0] vy_ext, ny;
  logic signed [VEL_W:0]   vy_dec;
  logic signed [VEL_W-1:0] vy_fall;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state_q <= GROUNDED;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q    <= '0;
      pos_x_q  <= X_INIT_P;
      pos_y_q  <= Y_GROUND_P;
      vy_q     <= '0;
      facing_q <= (FACE_INIT != 0);
      armed_q  <= 1'b0;
      landed_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      vy_q     <= vy_d;
      facing_q <= facing_d;
      armed_q  <= armed_d;
      landed_q <= landed_d;
    end
  end

  // Candidate positions and velocity, widened so clamps see true over/underflow.
  always_comb begin
    tick_w = (cnt_q == CNT_LAST);
    cnt_d  = tick_w ? '0 : cnt_q + CNT_W'(1);
    upd    = tick_w & ~freeze;
    move_l = left & ~right;
    move_r = right & ~left;
    launch = upd & (state_q != AIRBORNE) & up & armed_q;

    nx = $signed({1'b0, pos_x_q});
    if (move_r)      nx = nx + STEP_E;
    else if (move_l) nx = nx - STEP_E;

    if (nx < X_MIN_E)      nx_clamped = X_MIN_P;
    else if (nx > X_MAX_E) nx_clamped = X_MAX_P;
    else                   nx_clamped = nx[POS_W-1:0];

    vy_ext      = {{(POS_W+2-VEL_W){vy_q[VEL_W-1]}}, vy_q};
    ny          = $signed({2'b00, pos_y_q}) - vy_ext;
    touchdown   = (ny >= Y_GROUND_E);
    hit_ceiling = (ny < Y_MIN_E);

    vy_dec  = $signed({vy_q[VEL_W-1], vy_q}) - GRAV_E;
    vy_fall = (vy_dec < NEG_FALL_E) ? NEG_FALL_E[VEL_W-1:0] : vy_dec[VEL_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    if (upd) begin
      case (state_q)
        GROUNDED: begin
          if (launch)    state_d = AIRBORNE;
          else if (down) state_d = CROUCH;
        end
        CROUCH: begin
          if (launch)     state_d = AIRBORNE;
          else if (!down) state_d = GROUNDED;
        end
        AIRBORNE: begin
          if (touchdown) state_d = GROUNDED;
        end
        default: state_d = GROUNDED;
      endcase
    end
  end

  always_comb begin
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    vy_d     = vy_q;
    facing_d = facing_q;
    armed_d  = armed_q;
    landed_d = 1'b0;

    // Arming tracks up even while frozen so a held key cannot re-jump after hit-stun.
    if (tick_w && !up) armed_d = 1'b1;
    else if (launch)   armed_d = 1'b0;

    if (upd) begin
      if (move_l || move_r) facing_d = move_l;
      if (state_q != CROUCH || launch) pos_x_d = nx_clamped;
      if (launch) vy_d = JUMP_V;
      if (state_q == AIRBORNE) begin
        if (touchdown) begin
          pos_y_d  = Y_GROUND_P;
          vy_d     = '0;
          landed_d = 1'b1;
        end else if (hit_ceiling) begin
          pos_y_d = Y_MIN_P;
          vy_d    = '0;
        end else begin
          pos_y_d = ny[POS_W-1:0];
          vy_d    = vy_fall;
        end
      end
    end
  end

  always_comb begin
    pos_x  = pos_x_q;
    pos_y  = pos_y_q;
    facing = facing_q;
    state  = state_q;
    tick   = tick_w;
    landed = landed_q;
  end

endmodule
